// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 8-bit write-only bus driver.
// The init ROM is packed so that entry 0 is the first byte sent to the panel.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_EXEC,
    S_IDLE
  } state_t;

  localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;

  localparam int INIT_LEN = 6;
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    CMD_ENTRY, CMD_CLEAR, CMD_DISP_ON, CMD_FUNC_8BIT, CMD_FUNC_8BIT, CMD_FUNC_8BIT
  };

  // Clear display (0x01) and return home (0x02/0x03) need the long busy wait.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
// Reset preloads RESET_VAL so the power-up wait starts without an explicit load.
module lcd_delay_counter #(
  parameter int               CNT_W     = 20,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit write-only timing engine: runs the power-on init sequence,
// then paces core command/data writes with setup, EN pulse, hold and busy waits.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 25,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 2500,
  parameter int CLEAR_CYC   = 82000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic [7:0] DATA,
  output logic       RW,
  output logic       EN,
  output logic       RS,
  output logic       ON
);

  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);

  state_t           state, state_n;
  logic [2:0]       idx, idx_next;
  logic             cnt_load, cnt_done;
  logic [CNT_W-1:0] cnt_val;
  logic             byte_load, rs_n, idx_inc, init_set;
  logic [7:0]       byte_n;

  lcd_delay_counter #(
    .CNT_W    (CNT_W),
    .RESET_VAL(PWR_LD)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .done    (cnt_done)
  );

  assign idx_next  = idx + 3'd1;
  assign req_ready = (state == S_IDLE);
  assign RW        = 1'b0;

  always_comb begin
    state_n   = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    byte_load = 1'b0;
    byte_n    = DATA;
    rs_n      = RS;
    idx_inc   = 1'b0;
    init_set  = 1'b0;
    case (state)
      S_PWR_WAIT: if (cnt_done) begin
        state_n   = S_SETUP;
        cnt_load  = 1'b1;
        cnt_val   = SETUP_LD;
        byte_load = 1'b1;
        byte_n    = INIT_ROM[0];
        rs_n      = 1'b0;
      end
      S_SETUP: if (cnt_done) begin
        state_n  = S_EN_HI;
        cnt_load = 1'b1;
        cnt_val  = EN_LD;
      end
      S_EN_HI: if (cnt_done) begin
        state_n  = S_HOLD;
        cnt_load = 1'b1;
        cnt_val  = HOLD_LD;
      end
      S_HOLD: if (cnt_done) begin
        state_n  = S_EXEC;
        cnt_load = 1'b1;
        cnt_val  = is_clear_home(RS, DATA) ? CLEAR_LD : EXEC_LD;
      end
      S_EXEC: if (cnt_done) begin
        if (!init_done) begin
          idx_inc = 1'b1;
          if (idx_next < 3'(INIT_LEN)) begin
            state_n   = S_SETUP;
            cnt_load  = 1'b1;
            cnt_val   = SETUP_LD;
            byte_load = 1'b1;
            byte_n    = INIT_ROM[idx_next];
            rs_n      = 1'b0;
          end else begin
            init_set = 1'b1;
            state_n  = S_IDLE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_IDLE: if (req_valid) begin
        state_n   = S_SETUP;
        cnt_load  = 1'b1;
        cnt_val   = SETUP_LD;
        byte_load = 1'b1;
        byte_n    = req_data;
        rs_n      = req_rs;
      end
      default: state_n = S_PWR_WAIT;
    endcase
  end

  // EN is registered off the next state so the strobe is glitch-free at the pin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_PWR_WAIT;
      idx       <= 3'd0;
      init_done <= 1'b0;
      DATA      <= 8'd0;
      RS        <= 1'b0;
      EN        <= 1'b0;
      ON        <= 1'b0;
    end else begin
      state <= state_n;
      ON    <= 1'b1;
      EN    <= (state_n == S_EN_HI);
      if (byte_load) begin
        DATA <= byte_n;
        RS   <= rs_n;
      end
      if (idx_inc) idx <= idx_next;
      if (init_set) init_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with shortened timing parameters.
// Expected pulse widths, gaps and busy times are hand-derived from those parameters.
module tb_lcd_bus_driver;

  localparam int POWERUP_CYC = 100;
  localparam int SETUP_CYC   = 2;
  localparam int EN_HIGH_CYC = 5;
  localparam int HOLD_CYC    = 2;
  localparam int EXEC_CYC    = 20;
  localparam int CLEAR_CYC   = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rs, init_done;
  logic [7:0] req_data, DATA;
  logic       RW, EN, RS, ON;

  int checks = 0;
  int errors = 0;
  logic [7:0] initBytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_bus_driver #(
    .POWERUP_CYC(POWERUP_CYC),
    .SETUP_CYC  (SETUP_CYC),
    .EN_HIGH_CYC(EN_HIGH_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .EXEC_CYC   (EXEC_CYC),
    .CLEAR_CYC  (CLEAR_CYC),
    .CNT_W      (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs   (req_rs),
    .req_data (req_data),
    .init_done(init_done),
    .DATA     (DATA),
    .RW       (RW),
    .EN       (EN),
    .RS       (RS),
    .ON       (ON)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rs, input logic [7:0] d);
    req_valid = v;
    req_rs    = rs;
    req_data  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called on the first sample after reset release; follows the whole init sequence.
  task automatic runInit;
    int lowN, highN, gapN, bad, expGap;
    checkOutput("onAfterRelease", 32'(ON), 32'd1);
    lowN = 0;
    while (!EN && lowN < 300) begin
      lowN++;
      tick;
    end
    checkOutput("pwrWaitLow", 32'(lowN >= POWERUP_CYC && lowN <= POWERUP_CYC + 2), 32'd1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("initData", 32'(DATA), 32'(initBytes[i]));
      checkOutput("initRs", 32'(RS), 32'd0);
      highN = 0;
      bad   = 0;
      while (EN && highN < 100) begin
        if (DATA !== initBytes[i] || RS !== 1'b0 || RW !== 1'b0) bad++;
        highN++;
        tick;
      end
      checkOutput("initPulse", 32'(highN), 32'(EN_HIGH_CYC));
      checkOutput("initStable", 32'(bad), 32'd0);
      gapN = 0;
      bad  = 0;
      while (!EN && !req_ready && gapN < 200) begin
        if (init_done !== 1'b0) bad++;
        gapN++;
        tick;
      end
      checkOutput("initDoneEarly", 32'(bad), 32'd0);
      if (i < 5) begin
        expGap = (initBytes[i] == 8'h01) ? HOLD_CYC + CLEAR_CYC + SETUP_CYC : HOLD_CYC + EXEC_CYC + SETUP_CYC;
        checkOutput("initGap", 32'(gapN), 32'(expGap));
        checkOutput("initNextEn", 32'(EN), 32'd1);
      end else begin
        checkOutput("initTail", 32'(gapN), 32'(HOLD_CYC + EXEC_CYC));
        checkOutput("readyAfterInit", 32'(req_ready), 32'd1);
        checkOutput("initDone", 32'(init_done), 32'd1);
      end
    end
  endtask

  // Offers one byte at a ready sample and times the resulting write from the accept edge.
  task automatic doWrite(input logic rs, input logic [7:0] d, input int expBusy,
                         input logic keepValid, input logic nextRs, input logic [7:0] nextD,
                         output int busy, output int lastHigh);
    int enRise, enHigh, rises, bad;
    logic prevEn;
    applyStimulus(1'b1, rs, d);
    checkOutput("readyAtOffer", 32'(req_ready), 32'd1);
    tick;
    applyStimulus(keepValid, nextRs, nextD);
    busy = 0; enRise = -1; enHigh = 0; rises = 0; bad = 0; lastHigh = -1; prevEn = 1'b0;
    while (!req_ready && busy < 200) begin
      if (EN && !prevEn) begin
        rises++;
        if (enRise < 0) enRise = busy;
      end
      if (EN) begin
        enHigh++;
        lastHigh = busy;
      end
      if (DATA !== d || RS !== rs) bad++;
      prevEn = EN;
      busy++;
      tick;
    end
    checkOutput("busyCycles", 32'(busy), 32'(expBusy));
    checkOutput("enRiseDelay", 32'(enRise), 32'(SETUP_CYC));
    checkOutput("enHighCycles", 32'(enHigh), 32'(EN_HIGH_CYC));
    checkOutput("enPulseCount", 32'(rises), 32'd1);
    checkOutput("busHeld", 32'(bad), 32'd0);
  endtask

  initial begin
    int busyA, lastA, busyB, lastB, waitN, extra;

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (3) tick;
    checkOutput("rstData", 32'(DATA), 32'd0);
    checkOutput("rstRs", 32'(RS), 32'd0);
    checkOutput("rstRw", 32'(RW), 32'd0);
    checkOutput("rstEn", 32'(EN), 32'd0);
    checkOutput("rstOn", 32'(ON), 32'd0);
    checkOutput("rstReady", 32'(req_ready), 32'd0);
    checkOutput("rstInitDone", 32'(init_done), 32'd0);

    rst = 1'b1;
    tick;
    runInit;

    // Character write, then clear vs. non-clear busy times including the 0x02/0x04 boundaries.
    doWrite(1'b1, 8'h41, 29, 1'b0, 1'b0, 8'hAA, busyA, lastA);
    doWrite(1'b0, 8'h01, 59, 1'b0, 1'b1, 8'hFF, busyA, lastA);
    doWrite(1'b1, 8'h01, 29, 1'b0, 1'b0, 8'h00, busyA, lastA);
    doWrite(1'b0, 8'h02, 59, 1'b0, 1'b0, 8'h00, busyA, lastA);
    doWrite(1'b0, 8'h04, 29, 1'b0, 1'b0, 8'h00, busyA, lastA);
    doWrite(1'b0, 8'h00, 29, 1'b0, 1'b0, 8'h00, busyA, lastA);

    // Back-to-back with req_valid held: second byte goes on the first idle cycle.
    doWrite(1'b1, 8'h48, 29, 1'b1, 1'b1, 8'h49, busyA, lastA);
    doWrite(1'b1, 8'h49, 29, 1'b0, 1'b0, 8'h00, busyB, lastB);
    checkOutput("enLowBetween", 32'(busyA - lastA - 1 + SETUP_CYC), 32'(HOLD_CYC + EXEC_CYC + SETUP_CYC));

    // Reset in the middle of an EN pulse, with a request pending across the replayed init.
    applyStimulus(1'b1, 1'b0, 8'h0C);
    tick;
    applyStimulus(1'b0, 1'b0, 8'h00);
    waitN = 0;
    while (!EN && waitN < 10) begin
      waitN++;
      tick;
    end
    tick;
    checkOutput("enBeforeReset", 32'(EN), 32'd1);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h55);
    tick;
    checkOutput("midRstEn", 32'(EN), 32'd0);
    checkOutput("midRstOn", 32'(ON), 32'd0);
    checkOutput("midRstData", 32'(DATA), 32'd0);
    checkOutput("midRstRs", 32'(RS), 32'd0);
    checkOutput("midRstInitDone", 32'(init_done), 32'd0);
    checkOutput("midRstReady", 32'(req_ready), 32'd0);
    tick;
    rst = 1'b1;
    tick;
    runInit;

    doWrite(1'b1, 8'h55, 29, 1'b0, 1'b0, 8'h00, busyA, lastA);
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      if (EN || !req_ready) extra++;
      tick;
    end
    checkOutput("singleWrite", 32'(extra), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
